// File: rtl/orr_unit.sv
// 32-bit bitwise-OR functional unit: combinational result with zero/all-ones
// flags, plus a registered copy of the result qualified by a valid flag.
module orr_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             is_zero,
    output logic             is_ones,
    output logic [WIDTH-1:0] out_q,
    output logic             valid_q
);

    // One OR gate per bit; there is no cross-bit interaction.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign out[i] = A[i] | B[i];
        end
    endgenerate

    assign is_zero = ~|out;
    assign is_ones = &out;

    // valid_q marks a capture on the most recent edge; out_q holds otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en;
            if (en) begin
                out_q <= out;
            end
        end
    end

endmodule

// File: tb/tb_orr_unit.sv
// Self-checking bench for orr_unit: directed corners, capture/reset scenarios,
// and a randomized regression against a behavioural reference model.
module tb_orr_unit;

    logic        clock;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        en;
    logic [31:0] out;
    logic        is_zero;
    logic        is_ones;
    logic [31:0] out_q;
    logic        valid_q;

    int passCount;
    int checkCount;

    orr_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .en      (en),
        .out     (out),
        .is_zero (is_zero),
        .is_ones (is_ones),
        .out_q   (out_q),
        .valid_q (valid_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: a result bit is set when at least one operand has it set.
    function automatic logic [31:0] refOr(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 32; k++) begin
            if (a[k] == 1'b1 || b[k] == 1'b1) r[k] = 1'b1;
        end
        return r;
    endfunction

    task automatic checkComb(input string name);
        logic [31:0] e;
        e = refOr(A, B);
        checkCount++;
        if (out !== e || is_zero !== (e == 32'd0) || is_ones !== (e == 32'hFFFF_FFFF))
            $display("[TB] FAIL %s: A=%h B=%h out=%h z=%b o=%b, expected out=%h z=%b o=%b",
                     name, A, B, out, is_zero, is_ones, e, (e == 32'd0), (e == 32'hFFFF_FFFF));
        else
            passCount++;
    endtask

    task automatic checkReg(input string name, input logic [31:0] eq, input logic ev);
        checkCount++;
        if (out_q !== eq || valid_q !== ev)
            $display("[TB] FAIL %s: out_q=%h valid_q=%b, expected out_q=%h valid_q=%b",
                     name, out_q, valid_q, eq, ev);
        else
            passCount++;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; A = 32'h1234_0000; B = 32'h0000_5678;
        #2;
        checkReg("reset_state", 32'd0, 1'b0);
        checkComb("reset_comb");
        @(posedge clock); #1;
        checkReg("reset_hold", 32'd0, 1'b0);
        @(negedge clock);
        reset = 1'b0; en = 1'b0;
    endtask

    task automatic test_corners();
        logic [31:0] ta [7];
        logic [31:0] tb [7];
        int bitPos;
        ta = '{32'h0000_0000, 32'hAAAA_AAAA, 32'h8000_0000, 32'h1234_5678,
               32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_0000};
        tb = '{32'h0000_0000, 32'h5555_5555, 32'h0000_0001, 32'h1234_5678,
               32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        for (int k = 0; k < 7; k++) begin
            A = ta[k]; B = tb[k];
            #10;
            checkComb($sformatf("corner_%0d", k));
        end
        // Explicit spec values, independent of the reference function.
        A = 32'h8000_0000; B = 32'h0000_0001; #10;
        checkCount++;
        if (out !== 32'h8000_0001 || is_zero !== 1'b0 || is_ones !== 1'b0)
            $display("[TB] FAIL corner_msb_lsb: out=%h z=%b o=%b, expected 80000001 0 0",
                     out, is_zero, is_ones);
        else passCount++;
        for (int k = 0; k < 8; k++) begin
            bitPos = $urandom_range(31, 0);
            A = 32'd0; B = 32'd0;
            if (k % 2 == 0) A[bitPos] = 1'b1; else B[bitPos] = 1'b1;
            #10;
            checkComb($sformatf("single_bit_%0d", bitPos));
        end
        for (int k = 0; k < 4; k++) begin
            A = $urandom; B = ~A; #10;
            checkComb("complement");
            B = A; #10;
            checkComb("idempotent");
        end
    endtask

    task automatic test_capture();
        @(negedge clock);
        reset = 1'b0; en = 1'b1; A = 32'h0F0F_0000; B = 32'h0000_F0F0;
        @(posedge clock); #1;
        checkReg("capture", 32'h0F0F_F0F0, 1'b1);
        @(negedge clock);
        en = 1'b0; A = $urandom; B = $urandom;
        @(posedge clock); #1;
        checkReg("capture_hold", 32'h0F0F_F0F0, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        en = 1'b1; A = 32'h0102_0304; B = 32'h1000_0000;
        #2;
        reset = 1'b1;
        #1;
        checkReg("async_reset", 32'd0, 1'b0);
        checkComb("async_reset_comb");
        @(posedge clock); #1;
        checkReg("reset_over_edge", 32'd0, 1'b0);
        @(negedge clock);
        reset = 1'b0; en = 1'b1; A = 32'hCAFE_0000; B = 32'h0000_BABE;
        @(posedge clock); #1;
        checkReg("post_reset_capture", 32'hCAFE_BABE, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] expQ;
        logic        expV;
        expQ = 32'hCAFE_BABE;
        expV = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clock);
            A  = $urandom;
            B  = $urandom;
            if (n % 50 == 0) B = ~A;
            if (n % 77 == 0) begin A = 32'd0; B = 32'd0; end
            en = 1'($urandom_range(1, 0));
            #1;
            checkComb("rand_comb");
            if (en) expQ = refOr(A, B);
            expV = en;
            @(posedge clock); #1;
            checkReg("rand_reg", expQ, expV);
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        reset = 1'b1; en = 1'b0; A = 32'd0; B = 32'd0;
        test_reset();
        test_corners();
        test_capture();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
